interrupt_acknowledge_sequencer: RTL

//  Control stage directly upstream of the in-service register.
//  - Consumes the priority resolver's one-hot winning request.
//  - Raises INT to the CPU and runs the 8086-mode two-pulse INTA sequence.
//  - Pulses latch_in_service with the frozen one-hot level into the in-service register.
//  - Drives the interrupt vector on the data bus.
//  - Produces the end_of_interrupt vector from EOI commands and, optionally, auto-EOI.

---
 rtl/interrupt_acknowledge_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/interrupt_acknowledge_sequencer.sv
// interrupt_acknowledge_sequencer
// Sits between the priority resolver and the in-service register. Raises INT,
// runs the 8086-style two-pulse INTA handshake, strobes the frozen winning
// level into the in-service register, drives the vector byte on the data bus
// and produces the registered one-cycle end-of-interrupt clear vector.
// Optional feature: define PIC_AUTO_EOI_EN to enable automatic EOI
// (gated at run time by auto_eoi_config).
module interrupt_acknowledge_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] vector_base,
    input  logic [7:0] highest_level_in_service,
    input  logic       nonspecific_eoi,
    input  logic       specific_eoi,
    input  logic [2:0] specific_eoi_level,
    input  logic       auto_eoi_config,
    output logic       interrupt_to_cpu,
    output logic       latch_in_service,
    output logic [7:0] interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2,
        ST_ACK2 = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [7:0] winner_q, winner_d;
    logic       int_q, int_d;
    logic       latch_q, latch_d;
    logic [7:0] interrupt_q, interrupt_d;
    logic [7:0] eoi_q, eoi_d;
    logic [7:0] dbo_q, dbo_d;
    logic       dboe_q, dboe_d;
    logic [7:0] aeoi_s;
    logic       fall_s;
    logic       rise_s;

    // Binary level of a one-hot winner; an empty winner reports level 7 (spurious).
    function automatic logic [2:0] encode_level(input logic [7:0] onehot);
        logic [2:0] lvl;
        lvl = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                lvl = i[2:0];
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

`ifndef PIC_AUTO_EOI_EN
    // The AEOI configuration bit has no effect in this build.
    logic unused_auto_eoi_s;
    assign unused_auto_eoi_s = auto_eoi_config;
`endif

    assign fall_s = inta_prev_q & ~interrupt_acknowledge_n;
    assign rise_s = ~inta_prev_q & interrupt_acknowledge_n;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            inta_prev_q <= 1'b1;
            winner_q    <= 8'h00;
            int_q       <= 1'b0;
            latch_q     <= 1'b0;
            interrupt_q <= 8'h00;
            eoi_q       <= 8'h00;
            dbo_q       <= 8'h00;
            dboe_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= interrupt_acknowledge_n;
            winner_q    <= winner_d;
            int_q       <= int_d;
            latch_q     <= latch_d;
            interrupt_q <= interrupt_d;
            eoi_q       <= eoi_d;
            dbo_q       <= dbo_d;
            dboe_q      <= dboe_d;
        end
    end

    // Next-state and next-output logic for the INTA handshake and EOI vector.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        int_d       = int_q;
        latch_d     = 1'b0;
        interrupt_d = 8'h00;
        dbo_d       = dbo_q;
        dboe_d      = dboe_q;
        aeoi_s      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (interrupt_request != 8'h00) begin
                    int_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    int_d   = 1'b0;
                end
            end
            ST_REQ: begin
                // INT stays up even if the request withdraws before INTA.
                if (fall_s) begin
                    winner_d    = interrupt_request;
                    latch_d     = 1'b1;
                    interrupt_d = interrupt_request;
                    int_d       = 1'b0;
                    state_d     = ST_ACK1;
                end else begin
                    int_d       = 1'b1;
                end
            end
            ST_ACK1: begin
                // The rise ending the first pulse is ignored; wait for the second fall.
                if (fall_s) begin
                    dbo_d   = {vector_base, encode_level(winner_q)};
                    dboe_d  = 1'b1;
                    state_d = ST_ACK2;
                end else begin
                    state_d = ST_ACK1;
                end
            end
            ST_ACK2: begin
                if (rise_s) begin
                    dbo_d   = 8'h00;
                    dboe_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef PIC_AUTO_EOI_EN
                    aeoi_s  = auto_eoi_config ? winner_q : 8'h00;
`endif
                end else begin
                    state_d = ST_ACK2;
                end
            end
            default: begin
                state_d = ST_IDLE;
                int_d   = 1'b0;
                dbo_d   = 8'h00;
                dboe_d  = 1'b0;
            end
        endcase
        eoi_d = (nonspecific_eoi ? highest_level_in_service : 8'h00)
              | (specific_eoi ? (8'd1 << specific_eoi_level) : 8'h00)
              | aeoi_s;
    end

    assign interrupt_to_cpu    = int_q;
    assign latch_in_service    = latch_q;
    assign interrupt           = interrupt_q;
    assign end_of_interrupt    = eoi_q;
    assign data_bus_out        = dbo_q;
    assign data_bus_out_enable = dboe_q;

endmodule
